// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, FSM state type
// and bit positions of the registered flag vector.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_BZ  = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;
  localparam int NUM_FLAGS  = 4;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifter and shift-add multiplier.
// done_o marks the cycle whose edge performs the final step; result_o/carry_o are valid then.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  logic               busy_q, busy_d;
  logic [3:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   step_val;
  logic               step_carry;
  logic [2*WIDTH-1:0] step_acc;

  // val_q is the shift operand for SHL/SHR and the (right-shifting) multiplier for MUL.
  always_comb begin
    step_val   = val_q;
    step_carry = 1'b0;
    step_acc   = acc_q;
    unique case (op_q)
      OP_SHL: begin
        step_val   = {val_q[WIDTH-2:0], 1'b0};
        step_carry = val_q[WIDTH-1];
      end
      OP_SHR: begin
        step_val   = {1'b0, val_q[WIDTH-1:1]};
        step_carry = val_q[0];
      end
      default: begin
        step_val = {1'b0, val_q[WIDTH-1:1]};
        if (val_q[0]) step_acc = acc_q + mcand_q;
      end
    endcase
  end

  always_comb begin
    busy_d  = busy_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (start_i) begin
      busy_d = 1'b1;
      op_d   = op_i;
      acc_d  = '0;
      if (op_i == OP_MUL) begin
        val_d   = b_i;
        mcand_d = {{WIDTH{1'b0}}, a_i};
        cnt_d   = CW'(WIDTH);
      end else begin
        val_d   = a_i;
        mcand_d = '0;
        cnt_d   = {1'b0, b_i[SHW-1:0]};
      end
    end else if (busy_q) begin
      val_d   = step_val;
      acc_d   = step_acc;
      mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign done_o   = busy_q && (cnt_q == CW'(1));
  assign result_o = (op_q == OP_MUL) ? step_acc[WIDTH-1:0] : step_val;
  assign carry_o  = (op_q == OP_MUL) ? (|step_acc[2*WIDTH-1:WIDTH]) : step_carry;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops answer one cycle after accept, shifts and
// multiply run through alu_iter. A response is held in DONE until retired.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output alu_state_e       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e           state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  logic [WIDTH:0]       sum_ext;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     sc_res;
  logic [NUM_FLAGS-1:0] sc_flags;
  logic                 accept, start_iter;
  logic                 iter_done, iter_carry;
  logic [WIDTH-1:0]     iter_res;

  // Handshake: a request transfers on an edge where in_valid && in_ready; a
  // response retires on an edge where out_valid && out_ready. Retire and a new
  // accept may share one edge, giving one single-cycle op per clock.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign start_iter = accept &&
                      ((op == OP_MUL) || (is_shift_op(op) && (b[SHW-1:0] != '0)));

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;

  always_comb begin
    sc_res   = '0;
    sc_flags = '0;
    unique case (op)
      OP_ADD: begin
        sc_res               = sum_ext[WIDTH-1:0];
        sc_flags[FLAG_CARRY] = sum_ext[WIDTH];
        sc_flags[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res               = diff;
        sc_flags[FLAG_CARRY] = (a < b);
        sc_flags[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_BZ:  sc_flags[FLAG_ZERO] = (a == '0);
      // Only reached with a zero shift amount: the operand passes through.
      OP_SHL, OP_SHR: sc_res = a;
      OP_MUL: sc_res = '0;
      default: sc_flags[FLAG_ERR] = 1'b1;
    endcase
    if ((op != OP_BZ) && !sc_flags[FLAG_ERR]) sc_flags[FLAG_ZERO] = (sc_res == '0);
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flags_d = flags_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
        if (accept) begin
          if (start_iter) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DONE;
            res_d   = sc_res;
            flags_d = sc_flags;
          end
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          state_d              = ST_DONE;
          res_d                = iter_res;
          flags_d              = '0;
          flags_d[FLAG_ZERO]   = (iter_res == '0);
          flags_d[FLAG_CARRY]  = iter_carry;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_iter),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .done_o   (iter_done),
    .result_o (iter_res),
    .carry_o  (iter_carry)
  );

  assign result      = res_q;
  assign zero        = flags_q[FLAG_ZERO];
  assign carry       = flags_q[FLAG_CARRY];
  assign ovf         = flags_q[FLAG_OVF];
  assign err         = flags_q[FLAG_ERR];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=8): directed cases, hold/back-to-back, reset
// abort and randomized ops against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MAXU = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, carry, ovf, err;
  logic [W-1:0] result;
  alu_state_e   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v, e;
    int           lat;
  } exp_t;

  logic [W-1:0] exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .ovf         (ovf),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int to_signed(input int u);
    return (u >= HALF) ? u - MAXU : u;
  endfunction

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    int ua, ub, s, k;
    longint p;
    ua = int'(x);
    ub = int'(y);
    k  = ub % W;
    r.res = '0; r.z = 1'b0; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 1;
    case (o)
      4'h0: begin
        r.res = W'(ua + ub);
        r.c   = (ua + ub) >= MAXU;
        s     = to_signed(ua) + to_signed(ub);
        r.v   = (s >= HALF) || (s < -HALF);
      end
      4'h1: begin
        r.res = W'(ua - ub);
        r.c   = ua < ub;
        s     = to_signed(ua) - to_signed(ub);
        r.v   = (s >= HALF) || (s < -HALF);
      end
      4'h2: r.res = x & y;
      4'h3: r.res = x | y;
      4'h4: r.res = x ^ y;
      4'h6: r.res = (ua < ub) ? W'(1) : W'(0);
      4'h7: r.z = (ua == 0);
      4'h8: begin
        r.res = W'((ua << k) % MAXU);
        r.c   = (k > 0) ? (((ua >> (W - k)) & 1) == 1) : 1'b0;
        r.lat = k + 1;
      end
      4'h9: begin
        r.res = W'(ua >> k);
        r.c   = (k > 0) ? (((ua >> (k - 1)) & 1) == 1) : 1'b0;
        r.lat = k + 1;
      end
      4'hA: begin
        p     = longint'(ua) * longint'(ub);
        r.res = W'(p % MAXU);
        r.c   = p >= MAXU;
        r.lat = W + 1;
      end
      default: r.e = 1'b1;
    endcase
    if (o != 4'h7 && !r.e) r.z = (r.res == '0);
    return r;
  endfunction

  // Issue one request from a negedge, wait for the response, check it, retire it.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input string tag);
    exp_t         e;
    int           lat;
    int           waits;
    logic [W-1:0] r0;
    logic [3:0]   f0;
    e = model(o, x, y);
    out_ready = (hold == 0);
    op = o; a = x; b = y; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check({tag, ".accept"}, 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, ".busy_ready"}, 64'(in_ready), 64'(0));
      @(negedge clk);
      lat++;
    end
    check({tag, ".valid"}, 64'(out_valid), 64'(1));
    check({tag, ".latency"}, 64'(lat), 64'(e.lat));
    check({tag, ".result"}, 64'(result), 64'(e.res));
    check({tag, ".flags"}, 64'({zero, carry, ovf, err}), 64'({e.z, e.c, e.v, e.e}));
    r0 = result;
    f0 = {zero, carry, ovf, err};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, ".hold_ready"}, 64'(in_ready), 64'(0));
      check({tag, ".hold_data"}, 64'({result, zero, carry, ovf, err}), 64'({r0, f0}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".retired"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    exp_t e;
    int   t;
    logic [3:0]   ro;
    logic [W-1:0] rx, ry;

    repeat (3) @(negedge clk);
    check("reset.valid", 64'(out_valid), 64'(0));
    check("reset.result", 64'(result), 64'(0));
    check("reset.flags", 64'({zero, carry, ovf, err}), 64'(0));
    check("reset.state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset.ready", 64'(in_ready), 64'(1));

    run_op(OP_ADD, 8'hF0, 8'h20, 0, "add_f0_20");
    run_op(OP_SUB, 8'h80, 8'h01, 0, "sub_80_01");
    run_op(OP_SUB, 8'h01, 8'h02, 0, "sub_01_02");
    run_op(OP_BZ,  8'h00, 8'h5A, 0, "bz_00");
    run_op(OP_BZ,  8'h33, 8'h00, 0, "bz_33");
    run_op(OP_MUL, 8'h0D, 8'h0B, 0, "mul_0d_0b");
    run_op(OP_MUL, 8'h10, 8'h10, 0, "mul_10_10");
    run_op(OP_SHL, 8'h81, 8'h03, 0, "shl_81_3");
    run_op(OP_SHR, 8'h81, 8'h01, 0, "shr_81_1");
    run_op(OP_SHL, 8'h81, 8'h00, 0, "shl_81_0");
    run_op(4'b0101, 8'hAA, 8'h55, 0, "illegal_5");
    run_op(OP_SLT, 8'h03, 8'hF0, 0, "slt_03_f0");
    run_op(OP_ADD, 8'h7F, 8'h01, 5, "add_hold5");

    // Back-to-back ADDs: one response per cycle, in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx = W'($urandom); ry = W'($urandom);
      e  = model(OP_ADD, rx, ry);
      exp_q.push_back(e.res);
      op = OP_ADD; a = rx; b = ry; in_valid = 1'b1;
      @(negedge clk);
      check("b2b.valid", 64'(out_valid), 64'(1));
      check("b2b.result", 64'(result), 64'(exp_q.pop_front()));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b.drained", 64'(out_valid), 64'(0));

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = W'($urandom);
      ry = W'($urandom);
      run_op(ro, rx, ry, $urandom_range(0, 2), $sformatf("rand%0d_op%0h", i, ro));
    end

    // Reset in the middle of a multiply: abandoned, outputs clear asynchronously.
    run_op(OP_ADD, 8'hF0, 8'h20, 0, "pre_reset_add");
    op = OP_MUL; a = 8'h0D; b = 8'h0B; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset.valid", 64'(out_valid), 64'(0));
    check("async_reset.result", 64'(result), 64'(0));
    check("async_reset.flags", 64'({zero, carry, ovf, err}), 64'(0));
    check("async_reset.state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) t++;
    end
    check("abandoned.responses", 64'(t), 64'(0));
    run_op(OP_ADD, 8'h01, 8'h01, 0, "post_reset_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal range 4..32); localparam SHW = $clog2(WIDTH).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid input 1 / in_ready output 1: request handshake; transfer when both high at a clk edge.
REQ-005 SHALL have ports op input 4, a input WIDTH, b input WIDTH: opcode and operands, sampled on transfer.
REQ-006 SHALL have ports out_valid output 1 / out_ready input 1: response handshake; response retires when both high at a clk edge.
REQ-007 SHALL have port result output WIDTH, registered result.
REQ-008 SHALL have ports zero, carry, ovf, err, each output 1: registered flags accompanying result.

Function
REQ-009 SHALL decode op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0110 SLT (unsigned, result 1/0), 0111 BZ, 1000 SHL, 1001 SHR (logical), 1010 MUL; all other codes illegal.
REQ-010 SHALL use FSM states IDLE, BUSY, DONE; out_valid = (state==DONE).
REQ-011 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-012 Single-cycle ops (ADD..BZ, illegal) SHALL go to DONE on the accept edge; out_valid high the next cycle (latency 1).
REQ-013 SHL/SHR SHALL shift one bit per cycle by amount b[SHW-1:0]; amount 0 goes directly to DONE (latency 1), else BUSY for amount cycles (latency amount+1).
REQ-014 MUL SHALL use shift-add, one multiplier bit per cycle, BUSY for exactly WIDTH cycles (latency WIDTH+1); result = low WIDTH bits of a*b.
REQ-015 Operands SHALL be captured at accept; input changes during BUSY/DONE have no effect.
REQ-016 In DONE with out_ready low, result and all flags SHALL hold stable; with out_ready high and in_valid high, a new request is accepted the same edge (back-to-back single-cycle ops sustain 1 per cycle).
REQ-017 zero SHALL be (result==0) for all ops except BZ, where result=0 and zero=(a==0).
REQ-018 carry SHALL be: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR last bit shifted out (0 for amount 0); MUL 1 when upper WIDTH product bits nonzero; else 0.
REQ-019 ovf SHALL be two's-complement signed overflow for ADD/SUB, 0 otherwise.
REQ-020 Illegal op SHALL give result 0, err=1, other flags 0, latency 1; err=0 for legal ops.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, result 0, zero/carry/ovf/err 0, out_valid 0, clear datapath registers, independent of clk.
REQ-022 Reset during BUSY SHALL abandon the operation; no response is ever produced for it.
REQ-023 First request after rst_n rises SHALL be accepted on the first clk edge with in_valid high.

Structure
REQ-024 Shared package alu_pkg SHALL hold opcode constants, FSM state typedef, and flag-bit indices.
REQ-025 Iterative shift/multiply datapath SHALL be one sub-module alu_iter (start, op, a, b -> done, result, carry); single-cycle ops and FSM stay in alu_pipe.

Verification (WIDTH=8)
REQ-026 ADD a=F0 b=20, out_ready=1 -> out_valid 1 cycle after accept, result 10, carry 1, ovf 0, zero 0.
REQ-027 SUB 80-01 -> 7F, ovf 1, carry 0; SUB 01-02 -> FF, carry 1, ovf 0; BZ a=00 -> result 00, zero 1.
REQ-028 MUL 0D*0B -> result 8F, carry 0, out_valid 9 cycles after accept, in_ready 0 throughout BUSY; MUL 10*10 -> 00, carry 1, zero 1.
REQ-029 SHL a=81 b=03 -> 08, carry 0, latency 4; SHR a=81 b=01 -> 40, carry 1, latency 2; SHL b=00 -> 81, latency 1; op 0101 -> err 1, result 00.
REQ-030 out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0; then 4 back-to-back ADDs with out_ready high -> one response per cycle in order.
REQ-031 rst_n low 3 cycles into MUL -> outputs 0, out_valid 0 asynchronously; after release ADD 01+01 -> 02 with latency 1.
